// File: rtl/vector_alu_pkg.sv
// Shared types for the vector ALU: opcode encoding and control FSM states.
package vector_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_MINU = 4'd8,
    OP_MAXU = 4'd9,
    OP_MIN  = 4'd10,
    OP_MAX  = 4'd11,
    OP_SEQ  = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vector_alu_lane.sv
// One element-wide ALU slice; purely combinational, replicated once per lane.
module vector_alu_lane
  import vector_alu_pkg::*;
#(
  parameter int EWIDTH = 32
) (
  input  logic [3:0]        alu_op,
  input  logic [EWIDTH-1:0] a,
  input  logic [EWIDTH-1:0] b,
  output logic [EWIDTH-1:0] r
);

  localparam int SHW = $clog2(EWIDTH);

  logic [SHW-1:0] sh;
  assign sh = b[SHW-1:0];

  // NOTE: every output of a combinational block gets a default before the
  // case; any path that leaves it unassigned would infer a latch.
  always_comb begin
    r = '0;
    case (alu_op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned($signed(a) >>> sh);
      OP_MINU: r = (a < b) ? a : b;
      OP_MAXU: r = (a > b) ? a : b;
      OP_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:  r = ($signed(a) > $signed(b)) ? a : b;
      OP_SEQ:  r = {{(EWIDTH-1){1'b0}}, (a == b)};
      default: r = '0;  // reserved opcodes write zero
    endcase
  end

endmodule

// File: rtl/vector_alu_pipe.sv
// Multi-cycle vector ALU: captures one instruction, sweeps LANES elements per
// cycle with vl/mask gating (mask-undisturbed), then holds the result until taken.
module vector_alu_pipe
  import vector_alu_pkg::*;
#(
  parameter  int VLEN   = 8,
  parameter  int EWIDTH = 32,
  parameter  int LANES  = 2,
  localparam int VLW    = $clog2(VLEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               alu_op,
  input  logic                     vx,
  input  logic                     vm,
  input  logic [VLW-1:0]           vl,
  input  logic [VLEN-1:0]          mask,
  input  logic [EWIDTH*VLEN-1:0]   src1,
  input  logic [EWIDTH*VLEN-1:0]   src2,
  input  logic [EWIDTH-1:0]        scalar,
  input  logic [EWIDTH*VLEN-1:0]   vd_old,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EWIDTH*VLEN-1:0]   result,
  output logic                     busy
);

  localparam int EIW = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam int IW  = $clog2(VLEN + LANES + 1);

  state_e                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [VLEN-1:0][EWIDTH-1:0]  result_q, result_d;
  logic [VLEN-1:0][EWIDTH-1:0]  a_q, b_q;
  logic [VLW-1:0]               vl_q;
  logic                         vm_q;
  logic [VLEN-1:0]              mask_q;
  logic [3:0]                   op_q;

  logic                         accept;
  logic [LANES-1:0][EWIDTH-1:0] lane_r;
  logic [LANES-1:0][EIW-1:0]    lane_el;
  logic [LANES-1:0]             lane_we;

  assign accept = in_valid && (state_q == IDLE);

  // Lane k works on element idx+k; elements past VLEN or vl, or masked off,
  // are never written so they keep their vd_old value.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [31:0] e;
    logic        in_range;
    assign e          = 32'(idx_q) + 32'(k);
    assign in_range   = e < 32'(VLEN);
    assign lane_el[k] = in_range ? e[EIW-1:0] : '0;
    assign lane_we[k] = in_range && (e < 32'(vl_q)) && (!vm_q || mask_q[lane_el[k]]);

    vector_alu_lane #(.EWIDTH(EWIDTH)) u_lane (
      .alu_op (op_q),
      .a      (a_q[lane_el[k]]),
      .b      (b_q[lane_el[k]]),
      .r      (lane_r[k])
    );
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d  = EXEC;
        idx_d    = '0;
        result_d = vd_old;
      end
      EXEC: begin
        for (int k = 0; k < LANES; k++) begin
          if (lane_we[k]) result_d[lane_el[k]] = lane_r[k];
        end
        idx_d = idx_q + IW'(LANES);
        if (32'(idx_q) + 32'(LANES) >= 32'(vl_q)) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  // NOTE: operand capture registers carry no reset; they are always loaded on
  // accept before being read, so resetting them would only cost routing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= src1;
      b_q    <= vx ? {VLEN{scalar}} : src2;
      vl_q   <= (vl > VLW'(VLEN)) ? VLW'(VLEN) : vl;
      vm_q   <= vm;
      mask_q <= mask;
      op_q   <= alu_op;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule
